// File: rtl/blockmem_fifo_pkg.sv
// Shared helpers for the block-RAM backed FWFT FIFO: pointer wrap and count/level widths.
package blockmem_fifo_pkg;

  // Words that can sit outside the RAM: doutb register plus output register.
  localparam int unsigned PIPE_STAGES = 2;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int unsigned max_level(input int unsigned depth);
    return depth + PIPE_STAGES;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(max_level(depth) + 32'd1);
  endfunction

endpackage

// File: rtl/blockmem_2p.sv
// Simple dual-port block RAM: write on port A, registered read on port B.
// doutb only updates on enb, so it holds the last read word otherwise.
module blockmem_2p #(
  parameter int          G_USEIP     = 0,
  parameter int unsigned G_DATAWIDTH = 32,
  parameter int unsigned G_MEMDEPTH  = 1024,
  parameter int unsigned G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int          G_BWENABLE  = 0,
  parameter string       G_INIT_FILE = "",
  localparam int unsigned WE_W       = (G_BWENABLE != 0) ? G_DATAWIDTH / 8 : 1
) (
  input  logic                   clka,
  input  logic                   ena,
  input  logic [WE_W-1:0]        wea,
  input  logic [G_ADDRWIDTH-1:0] addra,
  input  logic [G_DATAWIDTH-1:0] dina,
  input  logic                   clkb,
  input  logic                   enb,
  input  logic [G_ADDRWIDTH-1:0] addrb,
  output logic [G_DATAWIDTH-1:0] doutb
);

  localparam int unsigned LANE_W     = G_DATAWIDTH / WE_W;
  localparam bit          VENDOR_MAP = (G_USEIP != 0) || (G_INIT_FILE != "");

  logic [G_DATAWIDTH-1:0] mem [G_MEMDEPTH];

  always_ff @(posedge clka) begin
    if (ena) begin
      for (int unsigned i = 0; i < WE_W; i++) begin
        if (wea[i]) mem[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
      end
    end
  end

  // Vendor flows bind their macro (and any preload image) to the g_ip scope; behaviour is identical.
  if (VENDOR_MAP) begin : g_ip
    always_ff @(posedge clkb) begin
      if (enb) doutb <= mem[addrb];
    end
  end else begin : g_infer
    always_ff @(posedge clkb) begin
      if (enb) doutb <= mem[addrb];
    end
  end

endmodule

// File: rtl/blockmem_fifo_ctrl.sv
// First-word-fall-through FIFO around one blockmem_2p: RAM write from the input stream,
// RAM read into a two-stage prefetch (doutb register, output register) for one word per clock.
module blockmem_fifo_ctrl
  import blockmem_fifo_pkg::*;
#(
  parameter int          G_USEIP       = 0,
  parameter int unsigned G_DATAWIDTH   = 32,
  parameter int unsigned G_MEMDEPTH    = 1024,
  parameter int unsigned G_ADDRWIDTH   = $clog2(G_MEMDEPTH),
  parameter int unsigned G_LVLWIDTH    = lvl_width(G_MEMDEPTH),
  parameter int          G_AFULL_LEVEL = G_MEMDEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [G_DATAWIDTH-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [G_DATAWIDTH-1:0] m_data,
  output logic [G_LVLWIDTH-1:0]  level,
  output logic                   almost_full
);

  localparam int unsigned      CNT_W     = cnt_width(G_MEMDEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(G_MEMDEPTH);
  localparam int unsigned      AFULL_CMP = (G_AFULL_LEVEL < 0) ? 32'd0 : 32'(G_AFULL_LEVEL);

  logic [G_ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [G_ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       ram_count_q, ram_count_d;
  logic                   a_valid_q, a_valid_d;
  logic                   b_valid_q, b_valid_d;
  logic [G_DATAWIDTH-1:0] m_data_q, m_data_d;
  logic                   s_ready_q, s_ready_d;
  logic [G_LVLWIDTH-1:0]  level_q, level_d;
  logic                   almost_full_q, almost_full_d;

  logic                   b_free;
  logic                   a_moves;
  logic                   wr_en;
  logic                   rd_issue;
  logic [G_DATAWIDTH-1:0] doutb;

  // Reads are gated by ram_count, so a slot is never read on the edge it is written.
  always_comb begin
    b_free   = !b_valid_q || m_ready;
    a_moves  = a_valid_q && b_free;
    wr_en    = s_valid && s_ready_q && !flush;
    rd_issue = (ram_count_q != '0) && (!a_valid_q || a_moves) && !flush;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q + CNT_W'(wr_en) - CNT_W'(rd_issue);
    a_valid_d   = a_valid_q;
    b_valid_d   = b_valid_q;
    m_data_d    = m_data_q;

    if (wr_en)    wr_ptr_d = G_ADDRWIDTH'(ptr_next(32'(wr_ptr_q), G_MEMDEPTH));
    if (rd_issue) rd_ptr_d = G_ADDRWIDTH'(ptr_next(32'(rd_ptr_q), G_MEMDEPTH));

    if (rd_issue)     a_valid_d = 1'b1;
    else if (a_moves) a_valid_d = 1'b0;

    if (a_moves) begin
      b_valid_d = 1'b1;
      m_data_d  = doutb;
    end else if (b_valid_q && m_ready) begin
      b_valid_d = 1'b0;
    end

    // Flush drops everything in flight but leaves the last output word on m_data.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      a_valid_d   = 1'b0;
      b_valid_d   = 1'b0;
      m_data_d    = m_data_q;
    end

    s_ready_d     = (ram_count_d != CNT_FULL);
    level_d       = G_LVLWIDTH'(ram_count_d) + G_LVLWIDTH'(a_valid_d) + G_LVLWIDTH'(b_valid_d);
    almost_full_d = !flush && (32'(level_d) >= AFULL_CMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_count_q   <= '0;
      a_valid_q     <= 1'b0;
      b_valid_q     <= 1'b0;
      m_data_q      <= '0;
      s_ready_q     <= 1'b1;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_count_q   <= ram_count_d;
      a_valid_q     <= a_valid_d;
      b_valid_q     <= b_valid_d;
      m_data_q      <= m_data_d;
      s_ready_q     <= s_ready_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = b_valid_q;
  assign m_data      = m_data_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

  blockmem_2p #(
    .G_USEIP     (G_USEIP),
    .G_DATAWIDTH (G_DATAWIDTH),
    .G_MEMDEPTH  (G_MEMDEPTH),
    .G_ADDRWIDTH (G_ADDRWIDTH),
    .G_BWENABLE  (0),
    .G_INIT_FILE ("")
  ) u_ram (
    .clka  (clk),
    .ena   (wr_en),
    .wea   (wr_en),
    .addra (wr_ptr_q),
    .dina  (s_data),
    .clkb  (clk),
    .enb   (rd_issue),
    .addrb (rd_ptr_q),
    .doutb (doutb)
  );

endmodule
